rvfi_commit_serializer: RTL
===========================

# rvfi_commit_serializer

Parametrised commit-side front end for the RVFI monitor in the mp4 testbench. It accepts up to COMMIT_WIDTH retiring instructions per cycle from the out-of-order core's ROB and buffers them in program order. It presents them one per cycle to the monitor, with the running `rvfi.order` count and `rvfi.halt` generated internally. It replaces the single-commit `rvfi.commit`/`rvfi.order` hookup in `mp4_tb`.

## Interface
Parameters:
- COMMIT_WIDTH, 2: retire lanes per cycle; lane 0 is oldest.
- DEPTH, 8: buffer entries; power of two and ≥ COMMIT_WIDTH.
- PKT_W, 192: packed RVFI packet width, ≥ 64. Bits [63:32] are pc_rdata; bits [31:0] are pc_wdata. The remaining bits are opaque.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  COMMIT_WIDTH  per-lane retire valid; any mask allowed.
- in_pkt  in  COMMIT_WIDTH×PKT_W  per-lane packet.
- in_ready  out  1  the beat is accepted when in_ready is high.
- out_valid  out  1  head packet present; drive to `rvfi.commit`.
- out_ready  in  1  consumer accepts head; tied to 1 for the monitor.
- out_pkt  out  PKT_W  head packet.
- out_order  out  64  order number of the head packet; drive to `rvfi.order`.
- out_halt  out  1  head packet is a halt; drive to `rvfi.halt`.
- count  out  $clog2(DEPTH)+1  current occupancy.
- halted  out  1  sticky flag: a halt packet has been accepted.

## Operation
- Storage is a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy register.
- Push:
  - The beat is accepted when any in_valid bit is high and in_ready is high.
  - in_ready = !halted && (DEPTH − count) ≥ COMMIT_WIDTH. This is computed from registered count only; a same-cycle pop does not free space for that cycle.
  - Accepting is all-or-none. Valid lanes are compacted in ascending lane order into consecutive entries starting at the write pointer.
  - Invalid lanes are skipped and do not consume entries.
- Halt detection on input:
  - A valid lane is a halt when pc_rdata == pc_wdata.
  - On an accepted beat, the lowest valid halt lane is written. Valid lanes above it in the same beat are dropped, and halted is set.
  - While halted, in_ready = 0 until rst.
- Pop:
  - out_valid = (count ≠ 0).
  - out_pkt is the entry at the read pointer.
  - The head is popped when out_valid and out_ready are both high.
- Order:
  - A 64-bit counter increments by 1 on each pop.
  - out_order equals the counter value, so the first popped packet carries order 0.
- out_halt = out_valid && (out_pkt[63:32] == out_pkt[31:0]).
- Occupancy: count_next = count + pushed_lanes − pop. Push and pop in the same cycle are both honoured.
- Pointers wrap modulo DEPTH.
- Reset clears the pointers, count, the order counter and halted, discarding any buffered packets mid-drain. Storage contents are don't-care.

## Timing
- Reset values: out_valid 0, out_order 0, out_halt 0, count 0, halted 0, in_ready 1.
- Latency: a packet accepted at edge N appears on out_valid/out_pkt in the cycle after edge N (1 cycle). Output is read combinationally from registered storage.
- Throughput: 1 pop per cycle. Pushes occur on at most one beat per cycle, of up to COMMIT_WIDTH lanes.
- Full boundary: with count = DEPTH − COMMIT_WIDTH + 1, in_ready = 0 even if out_ready = 1 in that cycle. in_ready returns the cycle after the pop.
- Empty boundary: with count = 0, out_valid = 0 and a pop request is ignored. The order counter does not move.
- in_valid = 0 with in_ready = 1 does not change state.
- out_ready low holds out_pkt, out_order and out_halt stable.
- rst has priority over a simultaneous push or pop.

## Test plan
- Reset then single lane. Assert rst for 2 cycles, then push lane 0 with pc_rdata=0x60, pc_wdata=0x64. Required: out_valid high next cycle with out_order=0, out_halt=0, then count returns to 0.
- Dual retire with holes. Push mask 2'b11 (A, B), then 2'b10 (C). Required: pops in order A, B, C with out_order 0, 1, 2, and C written with no hole.
- Backpressure and full. With out_ready=0 and DEPTH=8, push 2 lanes for 4 beats. Required: count=8 and in_ready=0. Then raise out_ready for one cycle. Required: in_ready is still 0 in that cycle (count 7) and stays 0 until count ≤ 6.
- Wrap-around. Run 20 packets through DEPTH=8 with simultaneous push/pop each cycle. Required: all 20 packets emerge in program order, out_order runs 0..19, and count never exceeds 8.
- Halt. Push lane 0 with pc_rdata=pc_wdata=0x80 and lane 1 valid. Required: lane 1 dropped, halted=1, in_ready=0. The halt packet emerges with out_halt=1, and further in_valid is ignored.
- Reset mid-drain. With count=5 and out_order=3, pulse rst. Required: next cycle count=0, out_valid=0, out_order=0, halted=0.

Source files
------------

// File: rtl/rvfi_commit_serializer_if.sv
// rvfi_commit_serializer_if
// Bundle of the retire-side and monitor-side signals of rvfi_commit_serializer.
//   in_valid / in_pkt / in_ready   : multi-lane retire beat from the ROB
//   out_valid / out_ready / out_pkt: one packet per cycle towards the RVFI monitor
//   out_order / out_halt           : rvfi.order and rvfi.halt for the head packet
//   count / halted                 : occupancy and sticky halt status
// Modport slave is the serializer's view; master is the producer/consumer side.
interface rvfi_commit_serializer_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PKT_W        = 192
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [COMMIT_WIDTH-1:0]            in_valid;
  logic [COMMIT_WIDTH-1:0][PKT_W-1:0] in_pkt;
  logic                               in_ready;
  logic                               out_valid;
  logic                               out_ready;
  logic [PKT_W-1:0]                   out_pkt;
  logic [63:0]                        out_order;
  logic                               out_halt;
  logic [CNT_W-1:0]                   count;
  logic                               halted;

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt, out_order, out_halt, count, halted
  );

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt, out_order, out_halt, count, halted
  );
endinterface

// File: rtl/rvfi_commit_serializer.sv
// rvfi_commit_serializer
// Accepts up to COMMIT_WIDTH retiring instructions per cycle (lane 0 oldest),
// stores them in program order in a DEPTH-entry circular buffer and presents
// them one per cycle to the RVFI monitor together with a running 64-bit order
// number and a halt flag.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (pointers, count, order, halted)
//   bus : rvfi_commit_serializer_if.slave
//         in_valid/in_pkt/in_ready  retire beat, accepted all-or-none
//         out_valid/out_ready/out_pkt  head packet handshake
//         out_order/out_halt  rvfi.order / rvfi.halt of the head
//         count/halted  occupancy and sticky halt flag
// A packet is a halt when pc_rdata (bits 63:32) equals pc_wdata (bits 31:0).
module rvfi_commit_serializer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PKT_W        = 192
) (
  input logic                     clk,
  input logic                     rst,
  rvfi_commit_serializer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(COMMIT_WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  // A halt packet is a self-loop: next pc equals current pc.
  function automatic logic is_halt(input logic [63:0] pc_pair);
    return (pc_pair[63:32] == pc_pair[31:0]);
  endfunction

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [63:0]      order_r;
  logic             halted_r;

  logic                             in_ready_s;
  logic                             accept_s;
  logic                             pop_s;
  logic                             out_valid_s;
  logic [PKT_W-1:0]                 head_pkt_s;
  logic [COMMIT_WIDTH-1:0]          keep_s;
  logic [COMMIT_WIDTH-1:0][AW-1:0]  lane_off_s;
  logic [CW-1:0]                    pushed_s;
  logic                             push_halt_s;

  // Space check uses the registered count only, so a same-cycle pop never
  // opens room for the beat presented in that cycle.
  assign in_ready_s  = !halted_r && ((DEPTH_C - count_r) >= LANES_C);
  assign accept_s    = (|bus.in_valid) && in_ready_s;
  assign out_valid_s = (count_r != ZERO_C);
  assign pop_s       = out_valid_s && bus.out_ready;
  assign head_pkt_s  = mem_r[rd_ptr_r];

  // Lane compaction: each kept lane gets the next free slot offset; lanes
  // above the lowest valid halt lane are dropped.
  always_comb begin
    logic          halt_seen_v;
    logic [CW-1:0] n_v;
    halt_seen_v = 1'b0;
    n_v         = ZERO_C;
    keep_s      = {COMMIT_WIDTH{1'b0}};
    lane_off_s  = {(COMMIT_WIDTH*AW){1'b0}};
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_off_s[i] = n_v[AW-1:0];
      if (bus.in_valid[i] && !halt_seen_v) begin
        keep_s[i] = 1'b1;
        n_v       = n_v + ONE_C;
        if (is_halt(bus.in_pkt[i][63:0])) begin
          halt_seen_v = 1'b1;
        end else begin
          halt_seen_v = halt_seen_v;
        end
      end else begin
        keep_s[i] = 1'b0;
      end
    end
    if (accept_s) begin
      pushed_s    = n_v;
      push_halt_s = halt_seen_v;
    end else begin
      pushed_s    = ZERO_C;
      push_halt_s = 1'b0;
    end
  end

  // Storage write: kept lanes land in consecutive slots from the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && accept_s) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (keep_s[i]) begin
          mem_r[wr_ptr_r + lane_off_s[i]] <= bus.in_pkt[i];
        end
      end
    end
  end

  // Pointer, occupancy, order-counter and sticky-halt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_C;
      order_r  <= 64'd0;
      halted_r <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so the additions wrap modulo DEPTH.
      wr_ptr_r <= wr_ptr_r + pushed_s[AW-1:0];
      rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
      count_r  <= count_r + pushed_s - {{(CW-1){1'b0}}, pop_s};
      order_r  <= order_r + {63'd0, pop_s};
      halted_r <= halted_r | push_halt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pkt   = head_pkt_s;
  assign bus.out_order = order_r;
  assign bus.out_halt  = out_valid_s && is_halt(head_pkt_s[63:0]);
  assign bus.count     = count_r;
  assign bus.halted    = halted_r;

endmodule
